// File: rtl/usb_line_pkg.sv
// Shared USB line-level definitions: bus line states, SYNC pattern,
// bit-stuffing run length, EOP length and the transmitter state encoding.
package usb_line_pkg;

    // Line states as {d_p, d_n}
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;

    localparam logic [7:0] SYNC_BYTE    = 8'h80;
    localparam int         STUFF_RUN    = 6;
    localparam int         EOP_SE0_BITS = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        DATA    = 3'd2,
        STUFF   = 3'd3,
        EOP_SE0 = 3'd4,
        EOP_J   = 3'd5,
        IPG     = 3'd6
    } tx_state_e;

endpackage

// File: rtl/usb_stuff_nrzi_enc.sv
// Bit stuffer and NRZI line encoder. Advances only on bit_strobe.
// Tracks the run of consecutive line 1s and the current NRZI level, and
// registers the {d_p, d_n} drive value for the bit being sent.
// Priority on a strobe: SE0 request, then level reset (drives J), then raw bit.
module usb_stuff_nrzi_enc
    import usb_line_pkg::*;
(
    input  logic clk48_host,
    input  logic reset_n,
    input  logic bit_strobe,
    input  logic raw_bit,
    input  logic se0_req,
    input  logic level_rst,
    output logic stuff_req,
    output logic d_p,
    output logic d_n
);

    logic       level_j;   // 1 = line currently at J, 0 = at K
    logic [2:0] ones_cnt;  // consecutive 1s sent since the last 0

    // Encode one bit per strobe: SE0, forced J, or NRZI of the raw bit
    always_ff @(posedge clk48_host or negedge reset_n) begin
        if (!reset_n) begin
            level_j  <= 1'b1;
            ones_cnt <= 3'd0;
            d_p      <= 1'b1;
            d_n      <= 1'b0;
        end else if (bit_strobe) begin
            if (se0_req) begin
                {d_p, d_n} <= LS_SE0;
            end else if (level_rst) begin
                level_j    <= 1'b1;
                ones_cnt   <= 3'd0;
                {d_p, d_n} <= LS_J;
            end else if (!raw_bit) begin
                // A 0 toggles the line and breaks any run of 1s
                level_j    <= ~level_j;
                ones_cnt   <= 3'd0;
                {d_p, d_n} <= level_j ? LS_K : LS_J;
            end else begin
                if (ones_cnt < 3'(STUFF_RUN)) begin
                    ones_cnt <= ones_cnt + 3'd1;
                end
                {d_p, d_n} <= level_j ? LS_J : LS_K;
            end
        end
    end

    // Once the run reaches STUFF_RUN the next bit on the line must be a 0
    assign stuff_req = (ones_cnt == 3'(STUFF_RUN));

endmodule

// File: rtl/usb_host_tx_phy.sv
// Host-side USB full-speed line transmitter. Frames each packet as SYNC,
// LSB-first data with bit stuffing, NRZI and EOP, then releases the bus for
// an inter-packet gap.
//
// Handshake: s_ready is a one-cycle pulse on the bit boundary where a byte
// is needed; the byte (and s_last) is taken when s_valid & s_ready. If
// s_valid is low on that cycle, underrun pulses instead and the packet is
// truncated straight into EOP. s_ready never depends on s_valid.
module usb_host_tx_phy
    import usb_line_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int IPG_BITS = 2
) (
    input  logic       clk48_host,
    input  logic       reset_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       usb_d_p_o,
    output logic       usb_d_n_o,
    output logic       usb_oe,
    output logic       busy,
    output logic       underrun,
    output tx_state_e  dbg_state
);

    localparam int TW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [TW-1:0] bit_tmr;
    logic          tick;

    tx_state_e     state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [3:0]    bits_left_q, bits_left_d;
    logic          last_q, last_d;
    logic [7:0]    hold_q, hold_d;
    logic          oe_q, oe_d;

    logic          enc_raw, enc_se0, enc_lrst, stuff_req;
    logic          ready_c, underrun_c;

    // Free-running bit timer; a new line bit starts after every tick edge
    always_ff @(posedge clk48_host or negedge reset_n) begin
        if (!reset_n) begin
            bit_tmr <= '0;
        end else if (bit_tmr == TW'(CLK_DIV - 1)) begin
            bit_tmr <= '0;
        end else begin
            bit_tmr <= bit_tmr + 1'b1;
        end
    end

    assign tick = (bit_tmr == '0);

    // FSM and datapath state register
    always_ff @(posedge clk48_host or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shift_q     <= 8'h00;
            bits_left_q <= 4'd0;
            last_q      <= 1'b0;
            hold_q      <= 8'd0;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bits_left_q <= bits_left_d;
            last_q      <= last_d;
            hold_q      <= hold_d;
            oe_q        <= oe_d;
        end
    end

    // Next-state logic: on each tick choose the next line bit and its source
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bits_left_d = bits_left_q;
        last_d      = last_q;
        hold_d      = hold_q;
        oe_d        = oe_q;
        enc_raw     = 1'b1;
        enc_se0     = 1'b0;
        enc_lrst    = 1'b0;
        ready_c     = 1'b0;
        underrun_c  = 1'b0;

        if (tick) begin
            unique case (state_q)
                IDLE, IPG: begin
                    oe_d     = 1'b0;
                    enc_lrst = 1'b1;
                    if ((state_q == IPG) && (hold_q < 8'(IPG_BITS))) begin
                        hold_d = hold_q + 8'd1;
                    end else if (s_valid) begin
                        // First SYNC bit; the remaining seven go through the shifter
                        state_d     = SYNC;
                        oe_d        = 1'b1;
                        enc_lrst    = 1'b0;
                        enc_raw     = SYNC_BYTE[0];
                        shift_d     = {1'b0, SYNC_BYTE[7:1]};
                        bits_left_d = 4'd7;
                        last_d      = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                SYNC, DATA, STUFF: begin
                    if (stuff_req) begin
                        state_d = STUFF;
                        enc_raw = 1'b0;
                    end else if (bits_left_q != 4'd0) begin
                        state_d     = (state_q == SYNC) ? SYNC : DATA;
                        enc_raw     = shift_q[0];
                        shift_d     = {1'b0, shift_q[7:1]};
                        bits_left_d = bits_left_q - 4'd1;
                    end else if (last_q) begin
                        state_d = EOP_SE0;
                        enc_se0 = 1'b1;
                        hold_d  = 8'd1;
                    end else begin
                        // Byte boundary: a new byte is required now
                        ready_c = 1'b1;
                        if (s_valid) begin
                            state_d     = DATA;
                            enc_raw     = s_data[0];
                            shift_d     = {1'b0, s_data[7:1]};
                            bits_left_d = 4'd7;
                            last_d      = s_last;
                        end else begin
                            underrun_c = 1'b1;
                            state_d    = EOP_SE0;
                            enc_se0    = 1'b1;
                            hold_d     = 8'd1;
                        end
                    end
                end
                EOP_SE0: begin
                    if (hold_q < 8'(EOP_SE0_BITS)) begin
                        enc_se0 = 1'b1;
                        hold_d  = hold_q + 8'd1;
                    end else begin
                        state_d  = EOP_J;
                        enc_lrst = 1'b1;
                    end
                end
                EOP_J: begin
                    state_d  = IPG;
                    oe_d     = 1'b0;
                    enc_lrst = 1'b1;
                    hold_d   = 8'd1;
                end
                default: begin
                    state_d  = IDLE;
                    oe_d     = 1'b0;
                    enc_lrst = 1'b1;
                end
            endcase
        end
    end

    usb_stuff_nrzi_enc u_enc (
        .clk48_host (clk48_host),
        .reset_n    (reset_n),
        .bit_strobe (tick),
        .raw_bit    (enc_raw),
        .se0_req    (enc_se0),
        .level_rst  (enc_lrst),
        .stuff_req  (stuff_req),
        .d_p        (usb_d_p_o),
        .d_n        (usb_d_n_o)
    );

    assign s_ready   = ready_c;
    assign underrun  = underrun_c;
    assign usb_oe    = oe_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_usb_host_tx_phy.sv
// Directed bench for usb_host_tx_phy: single byte, stuffing, two-byte packet,
// underrun truncation, mid-packet reset and back-to-back packets.
module tb_usb_host_tx_phy;

    localparam int CLK_DIV  = 4;
    localparam int IPG_BITS = 2;

    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    logic       clk;
    logic       reset_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic       usb_d_p_o;
    logic       usb_d_n_o;
    logic       usb_oe;
    logic       busy;
    logic       underrun;
    usb_line_pkg::tx_state_e dbg_state;

    int n_cmp;
    int n_err;

    // Captured packet
    logic [1:0] line_q [64];
    int         nbits;
    int         oe_cycles;
    int         rdy_cyc [8];
    int         rdy_n;
    int         und_n;
    int         und_bit;
    int         start_wait;
    logic [7:0] tx_bytes [4];

    usb_host_tx_phy #(.CLK_DIV(CLK_DIV), .IPG_BITS(IPG_BITS)) dut (
        .clk48_host (clk),
        .reset_n    (reset_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .usb_d_p_o  (usb_d_p_o),
        .usb_d_n_o  (usb_d_n_o),
        .usb_oe     (usb_oe),
        .busy       (busy),
        .underrun   (underrun),
        .dbg_state  (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Receiver-side NRZI decode: unchanged level is a 1
    function automatic logic nrzi_bit(input logic [1:0] prev, input logic [1:0] cur);
        return (prev == cur);
    endfunction

    // Offer tx_bytes[0..n-1]; s_last on the final one if last_on_final
    task automatic drive_bytes(input int n, input bit last_on_final, input bit hold_after);
        int idx;
        int guard;
        logic hs;
        idx   = 0;
        guard = 0;
        s_valid = 1'b1;
        s_data  = tx_bytes[0];
        s_last  = (n == 1) && last_on_final;
        while (idx < n && guard < 3000) begin
            @(negedge clk);
            guard++;
            hs = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                idx++;
                if (idx < n) begin
                    s_data = tx_bytes[idx];
                    s_last = (idx == n - 1) && last_on_final;
                end
            end
        end
        if (!hold_after) s_valid = 1'b0;
        n_cmp++;
        if (idx != n) begin
            n_err++;
            $display("FAIL drive_handshakes: got %0d bytes taken, required %0d", idx, n);
        end
    endtask

    // Record one packet: one line sample per bit while oe is high
    task automatic capture_packet();
        int guard;
        guard = 0; nbits = 0; oe_cycles = 0; rdy_n = 0; und_n = 0; und_bit = -1;
        while (!usb_oe && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        start_wait = guard - 1;
        n_cmp++;
        if (!usb_oe) begin
            n_err++;
            $display("FAIL capture_start: oe=%0b after %0d cycles, required 1", usb_oe, guard);
        end
        while (usb_oe && oe_cycles < 1000) begin
            if ((oe_cycles % CLK_DIV) == 0 && nbits < 64) begin
                line_q[nbits] = {usb_d_p_o, usb_d_n_o};
                nbits++;
            end
            if (s_ready) begin
                if (rdy_n < 8) rdy_cyc[rdy_n] = oe_cycles;
                rdy_n++;
            end
            if (underrun) begin
                und_n++;
                und_bit = nbits;
            end
            oe_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (busy) begin
            n_err++;
            $display("FAIL wait_idle: busy=%0b, required 0", busy);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({usb_oe, usb_d_p_o, usb_d_n_o, busy, s_ready, underrun} !== 6'b010000) begin
            n_err++;
            $display("FAIL reset_outputs: oe,p,n,busy,rdy,und=%b required 010000",
                     {usb_oe, usb_d_p_o, usb_d_n_o, busy, s_ready, underrun});
        end
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (dbg_state !== usb_line_pkg::IDLE || usb_oe !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: state=%0d oe=%0b busy=%0b required IDLE,0,0",
                     dbg_state, usb_oe, busy);
        end
    endtask

    task automatic test_single_byte();
        logic [1:0] exp_ls [19];
        int bad;
        exp_ls = '{K, J, K, J, K, J, K, K,  K, J, J, K, J, J, K, K,  SE0, SE0, J};
        tx_bytes[0] = 8'hA5;
        @(posedge clk); #1;
        fork
            drive_bytes(1, 1'b1, 1'b0);
            capture_packet();
        join
        n_cmp++;
        if (start_wait > CLK_DIV) begin
            n_err++;
            $display("FAIL single_latency: %0d cycles, required <= %0d", start_wait, CLK_DIV);
        end
        n_cmp++;
        if (oe_cycles != 76 || nbits != 19) begin
            n_err++;
            $display("FAIL single_length: oe_cycles=%0d bits=%0d required 76/19", oe_cycles, nbits);
        end
        bad = 0;
        for (int i = 0; i < 19; i++) if (line_q[i] !== exp_ls[i]) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL single_line: %0d wrong bits (bit8=%b bit16=%b), required 0", bad, line_q[8], line_q[16]);
        end
        n_cmp++;
        if (rdy_n != 1) begin
            n_err++;
            $display("FAIL single_ready: %0d pulses, required 1", rdy_n);
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_busy_ipg: busy=%0b during gap, required 1", busy);
        end
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (usb_oe !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_ipg: oe high %0d cycles, busy=%0b, required 0/0", bad, busy);
        end
        wait_idle();
    endtask

    task automatic test_stuff();
        logic [1:0] exp_ls [12];
        int bad;
        // data-phase 9 bits then SE0 SE0 J
        exp_ls = '{K, K, K, K, K, J, J, J, J, SE0, SE0, J};
        tx_bytes[0] = 8'hFF;
        @(posedge clk); #1;
        fork
            drive_bytes(1, 1'b1, 1'b0);
            capture_packet();
        join
        n_cmp++;
        if (nbits != 20) begin
            n_err++;
            $display("FAIL stuff_length: %0d bits, required 20", nbits);
        end
        bad = 0;
        for (int i = 0; i < 12; i++) if (line_q[8 + i] !== exp_ls[i]) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL stuff_line: %0d wrong bits (bit12=%b bit13=%b), required 0", bad, line_q[12], line_q[13]);
        end
        wait_idle();
    endtask

    task automatic test_two_bytes();
        logic [16:0] dec;
        tx_bytes[0] = 8'hC3;
        tx_bytes[1] = 8'hFC;
        @(posedge clk); #1;
        fork
            drive_bytes(2, 1'b1, 1'b0);
            capture_packet();
        join
        n_cmp++;
        if (rdy_n != 2 || (rdy_cyc[1] - rdy_cyc[0]) != 32) begin
            n_err++;
            $display("FAIL two_ready_spacing: %0d pulses, gap %0d, required 2 pulses gap 32",
                     rdy_n, rdy_cyc[1] - rdy_cyc[0]);
        end
        dec = '0;
        for (int i = 0; i < 17; i++) dec[i] = nrzi_bit(line_q[7 + i], line_q[8 + i]);
        n_cmp++;
        // C3, FC LSB first, then the stuffed 0 after the run of six 1s
        if (dec !== 17'b0_111111_00_11_0000_11) begin
            n_err++;
            $display("FAIL two_stream: got %b required %b", dec, 17'b0_111111_00_11_0000_11);
        end
        n_cmp++;
        if (nbits != 28 || line_q[25] !== SE0 || line_q[27] !== J) begin
            n_err++;
            $display("FAIL two_eop: bits=%0d bit25=%b bit27=%b required 28/00/10", nbits, line_q[25], line_q[27]);
        end
        wait_idle();
    endtask

    task automatic test_underrun();
        logic [7:0] dec;
        tx_bytes[0] = 8'h2D;
        @(posedge clk); #1;
        fork
            drive_bytes(1, 1'b0, 1'b0);
            capture_packet();
        join
        n_cmp++;
        if (und_n != 1 || und_bit != 16 || rdy_n != 2) begin
            n_err++;
            $display("FAIL underrun_pulse: count=%0d at bit %0d ready=%0d required 1/16/2",
                     und_n, und_bit, rdy_n);
        end
        n_cmp++;
        if (nbits != 19 || line_q[16] !== SE0 || line_q[17] !== SE0 || line_q[18] !== J) begin
            n_err++;
            $display("FAIL underrun_eop: bits=%0d bit16=%b required 19 bits, SE0 at 16", nbits, line_q[16]);
        end
        dec = '0;
        for (int i = 0; i < 8; i++) dec[i] = nrzi_bit(line_q[7 + i], line_q[8 + i]);
        n_cmp++;
        if (dec !== 8'h2D) begin
            n_err++;
            $display("FAIL underrun_data: got %h required 2d", dec);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid_packet();
        int guard;
        int bad;
        @(posedge clk); #1;
        s_valid = 1'b1; s_data = 8'h00; s_last = 1'b0;
        guard = 0;
        while (!usb_oe && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (40) @(negedge clk);
        n_cmp++;
        if (dbg_state !== usb_line_pkg::DATA) begin
            n_err++;
            $display("FAIL midreset_pre: state=%0d required DATA", dbg_state);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({usb_oe, usb_d_p_o, usb_d_n_o} !== 3'b010) begin
            n_err++;
            $display("FAIL midreset_async: oe,p,n=%b required 010", {usb_oe, usb_d_p_o, usb_d_n_o});
        end
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (usb_oe !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL midreset_idle: %0d active cycles, required 0", bad);
        end
        tx_bytes[0] = 8'h5A;
        @(posedge clk); #1;
        fork
            drive_bytes(1, 1'b1, 1'b0);
            capture_packet();
        join
        n_cmp++;
        if (nbits != 19 || line_q[0] !== K || line_q[18] !== J) begin
            n_err++;
            $display("FAIL midreset_next: bits=%0d bit0=%b required 19 bits starting K", nbits, line_q[0]);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int gap;
        tx_bytes[0] = 8'h3C;
        @(posedge clk); #1;
        fork
            drive_bytes(1, 1'b1, 1'b1);
            capture_packet();
        join
        n_cmp++;
        if (nbits != 19) begin
            n_err++;
            $display("FAIL b2b_first: %0d bits, required 19", nbits);
        end
        gap = 0;
        while (!usb_oe && gap < 100) begin
            gap++;
            @(negedge clk);
        end
        n_cmp++;
        if (gap != IPG_BITS * CLK_DIV) begin
            n_err++;
            $display("FAIL b2b_gap: %0d cycles, required %0d", gap, IPG_BITS * CLK_DIV);
        end
        fork
            drive_bytes(1, 1'b1, 1'b0);
            capture_packet();
        join
        n_cmp++;
        if (nbits != 19 || line_q[7] !== K || line_q[16] !== SE0) begin
            n_err++;
            $display("FAIL b2b_second: bits=%0d bit7=%b bit16=%b required 19/01/00", nbits, line_q[7], line_q[16]);
        end
        wait_idle();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single_byte();
        test_stuff();
        test_two_bytes();
        test_underrun();
        test_reset_mid_packet();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
